// File: rtl/ysyx_22050039_lsu.sv
// Load/store unit: one valid/ready data-memory transaction per accepted request,
// with byte-lane placement for stores and sign/zero extension for loads.
module ysyx_22050039_lsu #(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              misalign,
  output logic              stall,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wmask,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

  typedef struct packed {
    logic            wen;
    logic [1:0]      size;
    logic            uns;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  state_t              state, state_nxt;
  req_t                req_q;
  logic [XLEN-1:0]     rdata_q, load_ext, shifted;
  logic [2:0]          off;
  logic [5:0]          bit_off;
  logic [STRB_W-1:0]   base_mask;
  logic                aligned;
  logic                accept;

  assign accept  = (state == S_IDLE) && req_valid;
  assign off     = req_q.addr[2:0];
  assign bit_off = {off, 3'b000};
  assign shifted = mem_rdata >> bit_off;

  always_comb begin
    case (req_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~req_addr[0];
      2'd2:    aligned = (req_addr[1:0] == 2'b00);
      default: aligned = (req_addr[2:0] == 3'b000);
    endcase
  end

  always_comb begin
    case (req_q.size)
      2'd0:    base_mask = STRB_W'(8'h01);
      2'd1:    base_mask = STRB_W'(8'h03);
      2'd2:    base_mask = STRB_W'(8'h0F);
      default: base_mask = STRB_W'(8'hFF);
    endcase
  end

  // Doubleword loads fill the whole register, so req_unsigned is moot there.
  always_comb begin
    case (req_q.size)
      2'd0:    load_ext = req_q.uns ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                    : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = req_q.uns ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                    : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      2'd2:    load_ext = req_q.uns ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                    : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid)  state_nxt = aligned ? S_REQ : S_ERR;
      S_REQ:   if (mem_ready)  state_nxt = req_q.wen ? S_DONE : S_WAIT;
      S_WAIT:  if (mem_rvalid) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    // Qualified by rst so every output except req_ready is 0 while in reset.
    stall      = (accept && rst) || (state == S_REQ) || (state == S_WAIT);
    mem_valid  = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    resp_valid = (state == S_DONE) || (state == S_ERR);
    misalign   = (state == S_ERR);
    if (state == S_REQ) begin
      mem_valid = 1'b1;
      mem_wen   = req_q.wen;
      mem_addr  = {req_q.addr[XLEN-1:3], 3'b000};
      if (req_q.wen) begin
        mem_wdata = req_q.wdata << bit_off;
        mem_wmask = base_mask << off;
      end
    end
  end

  assign resp_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q <= '{wen: req_wen, size: req_size, uns: req_unsigned,
                   addr: req_addr, wdata: req_wdata};
        if (!aligned) rdata_q <= '0;
      end
      if (state == S_REQ && mem_ready && req_q.wen) rdata_q <= '0;
      if (state == S_WAIT && mem_rvalid)            rdata_q <= load_ext;
    end
  end

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Scoreboard bench for the LSU: directed vectors push expected bus and response
// records; a monitor pops and compares whenever the DUT presents them.
module tb_ysyx_22050039_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, misalign, stall, mem_valid, mem_wen;
  logic [63:0] resp_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;

  ysyx_22050039_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .misalign(misalign), .stall(stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [63:0] addr, wdata;
    logic [7:0]  wmask;
  } bus_t;
  typedef struct {
    logic [63:0] rdata;
    logic        mis;
  } resp_t;
  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [63:0] a, wd, rword;
    logic        bus;
    logic [63:0] eaddr, ewd;
    logic [7:0]  emask;
    logic [63:0] erd;
    logic        emis;
    int          dly;
  } vec_t;

  bus_t  bq[$];
  resp_t rq[$];
  vec_t  vecs[$];

  int          total = 0, bad = 0, nresp = 0;
  int          ready_dly = 0;
  logic        hold_rvalid = 1'b0;
  logic [63:0] rd_word = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event seen/missed with nothing expected", nm);
  endtask

  // Bus responder: raises mem_ready after ready_dly cycles of mem_valid and
  // returns rd_word one cycle after a load handshake.
  initial begin
    int   cnt;
    logic hs_ld;
    cnt = 0;
    forever begin
      @(negedge clk);
      hs_ld = mem_valid && mem_ready && !mem_wen;
      @(posedge clk);
      #1;
      if (!hold_rvalid) begin
        mem_rvalid = hs_ld;
        if (hs_ld) mem_rdata = rd_word;
      end
      if (mem_valid) begin
        mem_ready = (cnt >= ready_dly);
        cnt++;
      end else begin
        mem_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    bus_t  b;
    resp_t r;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        chk("stall_during_bus", 64'(stall), 64'd1);
        if (bq.size() == 0) flag("unexpected_mem_valid");
        else begin
          b = bq[0];
          chk("mem_wen",   64'(mem_wen),   64'(b.wen));
          chk("mem_addr",  mem_addr,       b.addr);
          chk("mem_wdata", mem_wdata,      b.wdata);
          chk("mem_wmask", 64'(mem_wmask), 64'(b.wmask));
          if (mem_ready) void'(bq.pop_front());
        end
      end
      if (resp_valid) begin
        chk("stall_at_resp", 64'(stall), 64'd0);
        chk("ready_at_resp", 64'(req_ready), 64'd0);
        if (rq.size() == 0) flag("unexpected_resp_valid");
        else begin
          r = rq.pop_front();
          chk("resp_rdata", resp_rdata,     r.rdata);
          chk("misalign",   64'(misalign),  64'(r.mis));
          nresp++;
        end
      end else if (misalign) flag("misalign_without_resp");
      if (req_valid && req_ready && rst) chk("stall_at_accept", 64'(stall), 64'd1);
    end
  end

  task automatic run_vec(input vec_t v);
    int n0, t;
    bus_t  b;
    resp_t r;
    n0 = nresp;
    t  = 0;
    ready_dly = v.dly;
    rd_word   = v.rword;
    if (v.bus) begin
      b = '{wen: v.w, addr: v.eaddr, wdata: v.ewd, wmask: v.emask};
      bq.push_back(b);
    end
    r = '{rdata: v.erd, mis: v.emis};
    rq.push_back(r);
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = v.w; req_size = v.sz; req_unsigned = v.u;
    req_addr = v.a; req_wdata = v.wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (nresp == n0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (nresp == n0) flag("resp_timeout");
  endtask

  initial begin
    int   t;
    int   n0;
    bus_t b;
    #200000;
    $display("FAIL watchdog: simulation did not end, got=hang want=finish");
    $fatal(1);
  end

  initial begin
    int   t, n0;
    bus_t b;
    vecs.push_back('{1'b0, 2'd3, 1'b0, 64'h80000010, 64'h0, 64'h1122334455667788, 1'b1,
                     64'h80000010, 64'h0, 8'h00, 64'h1122334455667788, 1'b0, 0});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 64'h80000013, 64'h0, 64'h0000000080000000, 1'b1,
                     64'h80000010, 64'h0, 8'h00, 64'hFFFFFFFFFFFFFF80, 1'b0, 0});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 64'h80000013, 64'h0, 64'h0000000080000000, 1'b1,
                     64'h80000010, 64'h0, 8'h00, 64'h0000000000000080, 1'b0, 0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 64'h80000006, 64'hBEEF, 64'h0, 1'b1,
                     64'h80000000, 64'hBEEF000000000000, 8'hC0, 64'h0, 1'b0, 0});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 64'h8000000A, 64'h0, 64'h0000000087650000, 1'b1,
                     64'h80000008, 64'h0, 8'h00, 64'hFFFFFFFFFFFF8765, 1'b0, 0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 64'h80000002, 64'h0, 64'h0, 1'b0,
                     64'h0, 64'h0, 8'h00, 64'h0, 1'b1, 0});
    vecs.push_back('{1'b0, 2'd2, 1'b1, 64'h80000004, 64'h0, 64'h89ABCDEF00000000, 1'b1,
                     64'h80000000, 64'h0, 8'h00, 64'h0000000089ABCDEF, 1'b0, 0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 64'h80000004, 64'h0, 64'h89ABCDEF00000000, 1'b1,
                     64'h80000000, 64'h0, 8'h00, 64'hFFFFFFFF89ABCDEF, 1'b0, 2});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 64'h80000007, 64'hAA, 64'h0, 1'b1,
                     64'h80000000, 64'hAA00000000000000, 8'h80, 64'h0, 1'b0, 1});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 64'h80000008, 64'h0123456789ABCDEF, 64'h0, 1'b1,
                     64'h80000008, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0, 0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 64'h80000004, 64'h1, 64'h0, 1'b0,
                     64'h0, 64'h0, 8'h00, 64'h0, 1'b1, 0});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 64'h80000001, 64'h0, 64'h0, 1'b0,
                     64'h0, 64'h0, 8'h00, 64'h0, 1'b1, 0});
    vecs.push_back('{1'b0, 2'd3, 1'b1, 64'h80000018, 64'h0, 64'hF000000000000001, 1'b1,
                     64'h80000018, 64'h0, 8'h00, 64'hF000000000000001, 1'b0, 0});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 64'h80000020, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b1,
                     64'h80000020, 64'h0, 8'h00, 64'hDEADBEEFCAFEF00D, 1'b0, 5});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 64'h80000104, 64'h12345678, 64'h0, 1'b1,
                     64'h80000100, 64'h1234567800000000, 8'hF0, 64'h0, 1'b0, 3});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready",  64'(req_ready),  64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_stall",      64'(stall),      64'd0);
    chk("rst_mem_valid",  64'(mem_valid),  64'd0);
    chk("rst_misalign",   64'(misalign),   64'd0);
    chk("rst_resp_rdata", resp_rdata,      64'd0);
    chk("rst_mem_wmask",  64'(mem_wmask),  64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while waiting for load data; the late rvalid must be dropped.
    hold_rvalid = 1'b1;
    ready_dly   = 0;
    b = '{wen: 1'b0, addr: 64'h80000040, wdata: 64'h0, wmask: 8'h00};
    bq.push_back(b);
    n0 = nresp;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h80000040;
    @(posedge clk); #1;
    req_valid = 1'b0;
    t = 0;
    while (!(mem_valid && mem_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) flag("abort_handshake_timeout");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_req_ready",  64'(req_ready),  64'd1);
    chk("abort_stall",      64'(stall),      64'd0);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    chk("abort_mem_valid",  64'(mem_valid),  64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h5555AAAA5555AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_no_resp",       64'(nresp - n0), 64'd0);
    chk("abort_idle_ready",    64'(req_ready),  64'd1);
    chk("abort_rdata_cleared", resp_rdata,      64'd0);
    hold_rvalid = 1'b0;

    run_vec('{1'b0, 2'd3, 1'b0, 64'h80000048, 64'h0, 64'h0F0E0D0C0B0A0908, 1'b1,
              64'h80000048, 64'h0, 8'h00, 64'h0F0E0D0C0B0A0908, 1'b0, 0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bus_queue_drained",  64'(bq.size()), 64'd0);
    chk("resp_queue_drained", 64'(rq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
